// File: rtl/pc_bus_pkg.sv
// pc_bus_pkg: state encoding and constants shared by the 8088 local-bus target
package pc_bus_pkg;
    localparam int CNT_W = 8;
    localparam logic [7:0] IDLE_DATA = 8'hFF;
    typedef enum logic [2:0] {IDLE, LATCHED, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD} state_t;
endpackage

// File: rtl/pc_bus_timeout.sv
// pc_bus_timeout: clear/increment wait counter that flags the cycle it reaches the limit
import pc_bus_pkg::*;
module pc_bus_timeout (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt;
    assign nxt = cnt + 1'b1;
    assign hit = inc && nxt == limit;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= nxt;
endmodule

// File: rtl/pc_bus_target.sv
// pc_bus_target: decodes an 8088 ALE/RD#/WR# cycle into a single local req/ack transaction
import pc_bus_pkg::*;
module pc_bus_target #(
    parameter logic [19:0] BASE    = 20'h00000,
    parameter logic [19:0] MASK    = 20'hF0000,
    parameter bit          IS_IO   = 1'b0,
    parameter int          TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ale,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        iom,
    input  logic [19:0] a,
    input  logic [7:0]  ad_i,
    output logic [7:0]  ad_o,
    output logic        ad_oe,
    output logic        ready,
    output logic        loc_req,
    output logic        loc_we,
    output logic [19:0] loc_addr,
    output logic [7:0]  loc_wdata,
    input  logic [7:0]  loc_rdata,
    input  logic        loc_ack,
    output logic        err
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    state_t      state;
    logic [19:0] addr;
    logic        sel;
    logic        to_hit;
    logic        done;
    logic        unused_a;
    assign addr     = {a[19:8], ad_i};
    assign sel      = ((addr ^ BASE) & MASK) == 20'h0 && iom == IS_IO;
    assign done     = loc_ack || to_hit;
    assign unused_a = ^a[7:0];
    pc_bus_timeout u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == LATCHED),
        .inc   (loc_req),
        .limit (LIMIT),
        .hit   (to_hit)
    );
    // loc_req outlives an aborted bus cycle, so its release is handled outside the state case
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            ad_o      <= '0;
            ad_oe     <= 1'b0;
            ready     <= 1'b1;
            loc_req   <= 1'b0;
            loc_we    <= 1'b0;
            loc_addr  <= '0;
            loc_wdata <= '0;
            err       <= 1'b0;
        end else begin
            err <= to_hit && !loc_ack;
            if (loc_req && done) loc_req <= 1'b0;
            case (state)
                IDLE:
                    if (ale && !loc_req) begin
                        loc_addr <= addr;
                        state    <= sel ? LATCHED : IDLE;
                    end
                LATCHED:
                    if (ale) begin
                        loc_addr <= addr;
                        state    <= sel ? LATCHED : IDLE;
                    end else if (!rd_n || !wr_n) begin
                        state   <= !rd_n ? RD_WAIT : WR_WAIT;
                        loc_we  <= rd_n;
                        loc_req <= 1'b1;
                        ready   <= 1'b0;
                        if (rd_n) loc_wdata <= ad_i;
                    end
                RD_WAIT:
                    if (done) begin
                        ready <= 1'b1;
                        ad_o  <= loc_ack ? loc_rdata : IDLE_DATA;
                        ad_oe <= !rd_n;
                        state <= rd_n ? IDLE : RD_DRIVE;
                    end else if (rd_n) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                RD_DRIVE:
                    if (rd_n) begin
                        ad_oe <= 1'b0;
                        state <= IDLE;
                    end
                WR_WAIT:
                    if (done || wr_n) begin
                        ready <= 1'b1;
                        state <= wr_n ? IDLE : WR_HOLD;
                    end
                WR_HOLD:
                    if (wr_n) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule
